// File: rtl/hwpe_stream_fifo_thr_pkg.sv
// Shared types for the thresholded HWPE-Stream FIFO: the status flag bundle
// exported by the FIFO controller and the top level.
package hwpe_stream_package;

  typedef struct packed {
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [7:0] level;
    logic [7:0] max_level;
  } flags_fifo_thr_t;

endpackage

// File: rtl/hwpe_stream_fifo_thr_if.sv
// HWPE-Stream handshake bundle: valid/ready plus data and byte strobe.
// The source side drives valid/data/strb; the sink side drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_fifo_thr_ctrl.sv
// FIFO bookkeeping: pointers, occupancy, handshakes and threshold flags.
// Optional high-watermark tracking under HWPE_STREAM_FIFO_THR_WATERMARK_EN.
module hwpe_stream_fifo_thr_ctrl
  import hwpe_stream_package::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FALL_THROUGH = 0,
  parameter int unsigned LVL_WIDTH    = $clog2(FIFO_DEPTH + 1),
  parameter int unsigned PTR_WIDTH    = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
  input  logic                 wm_clear,
`endif
  input  logic [LVL_WIDTH-1:0] almost_full_thr,
  input  logic [LVL_WIDTH-1:0] almost_empty_thr,
  input  logic                 push_valid,
  output logic                 push_ready,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic                 write,
  output logic                 bypass,
  output logic [PTR_WIDTH-1:0] push_ptr,
  output logic [PTR_WIDTH-1:0] pop_ptr,
  output flags_fifo_thr_t      flags_o
);

  localparam bit                   FT       = (FALL_THROUGH != 0);
  localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);

  logic [LVL_WIDTH-1:0] level_q, level_d;
  logic [PTR_WIDTH-1:0] push_ptr_q, pop_ptr_q;
  logic                 empty, full;
  logic                 push_fire, pop_fire, stored_push, stored_pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_WIDTH-1:0] wrap_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty       = (level_q == '0);
    full        = (level_q == LVL_FULL);
    push_ready  = !full;
    bypass      = FT && empty;
    pop_valid   = !empty || (FT && push_valid);
    push_fire   = push_valid && push_ready;
    pop_fire    = pop_valid && pop_ready;
    // A word that goes straight through an empty fall-through FIFO never lands in storage.
    stored_push = push_fire && !(bypass && pop_fire);
    stored_pop  = pop_fire && !bypass;
    write       = stored_push && !clear_i && !rst_i;
  end

  always_comb begin
    level_d = level_q;
    case ({stored_push, stored_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      level_q    <= '0;
      push_ptr_q <= '0;
      pop_ptr_q  <= '0;
    end else begin
      level_q <= level_d;
      if (stored_push) push_ptr_q <= wrap_inc(push_ptr_q);
      if (stored_pop)  pop_ptr_q  <= wrap_inc(pop_ptr_q);
    end
  end

  assign push_ptr = push_ptr_q;
  assign pop_ptr  = pop_ptr_q;

`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
  logic [LVL_WIDTH-1:0] max_level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      max_level_q <= '0;
    end else if (wm_clear) begin
      max_level_q <= level_q;
    end else if (level_q > max_level_q) begin
      max_level_q <= level_q;
    end
  end
`endif

  always_comb begin
    flags_o              = '0;
    flags_o.empty        = empty;
    flags_o.full         = full;
    flags_o.almost_full  = (level_q >= almost_full_thr);
    flags_o.almost_empty = (level_q <= almost_empty_thr);
    flags_o.level        = 8'(level_q);
`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
    flags_o.max_level    = 8'(max_level_q);
`else
    flags_o.max_level    = '0;
`endif
  end

endmodule

// File: rtl/hwpe_stream_fifo_thr.sv
// Thresholded HWPE-Stream FIFO: any depth >= 2, exact level, run-time almost
// flags, optional fall-through. Define HWPE_STREAM_FIFO_THR_WATERMARK_EN for max_level.
module hwpe_stream_fifo_thr
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FALL_THROUGH = 0,
  parameter int unsigned LVL_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
  input  logic                   wm_clear_i,
`endif
  input  logic [LVL_WIDTH-1:0]   almost_full_thr_i,
  input  logic [LVL_WIDTH-1:0]   almost_empty_thr_i,
  output flags_fifo_thr_t        flags_o,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [STRB_WIDTH-1:0] strb_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  push_ptr, pop_ptr;
  logic                  write, bypass, push_ready, pop_valid;

  hwpe_stream_fifo_thr_ctrl #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .FALL_THROUGH (FALL_THROUGH),
    .LVL_WIDTH    (LVL_WIDTH),
    .PTR_WIDTH    (PTR_WIDTH)
  ) i_ctrl (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
    .wm_clear         (wm_clear_i),
`endif
    .almost_full_thr  (almost_full_thr_i),
    .almost_empty_thr (almost_empty_thr_i),
    .push_valid       (push_i.valid),
    .push_ready       (push_ready),
    .pop_valid        (pop_valid),
    .pop_ready        (pop_o.ready),
    .write            (write),
    .bypass           (bypass),
    .push_ptr         (push_ptr),
    .pop_ptr          (pop_ptr),
    .flags_o          (flags_o)
  );

  // NOTE: storage carries no reset; the level counter alone decides which
  // entries are meaningful, so reset/clear never touch the array.
  always_ff @(posedge clk_i) begin
    if (write) begin
      data_q[push_ptr] <= push_i.data;
      strb_q[push_ptr] <= push_i.strb;
    end
  end

  assign push_i.ready = push_ready;
  assign pop_o.valid  = pop_valid;
  assign pop_o.data   = bypass ? push_i.data : data_q[pop_ptr];
  assign pop_o.strb   = bypass ? push_i.strb : strb_q[pop_ptr];

endmodule

// File: tb/tb_hwpe_stream_fifo_thr.sv
// Directed bench: a depth-5 registered-output FIFO driven from a vector table,
// plus hand sequences for fall-through, clear and the optional watermark.
module tb_hwpe_stream_fifo_thr;
  import hwpe_stream_package::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_i, clear_i, ft_clear;
  logic [LW-1:0] af_thr, ae_thr;
  logic          wm_clear;
  flags_fifo_thr_t flags, ft_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) ft_push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) ft_pop_if ();

  hwpe_stream_fifo_thr #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(0)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .clear_i            (clear_i),
`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
    .wm_clear_i         (wm_clear),
`endif
    .almost_full_thr_i  (af_thr),
    .almost_empty_thr_i (ae_thr),
    .flags_o            (flags),
    .push_i             (push_if),
    .pop_o              (pop_if)
  );

  hwpe_stream_fifo_thr #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(1)) dut_ft (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .clear_i            (ft_clear),
`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
    .wm_clear_i         (1'b0),
`endif
    .almost_full_thr_i  (af_thr),
    .almost_empty_thr_i (ae_thr),
    .flags_o            (ft_flags),
    .push_i             (ft_push_if),
    .pop_o              (ft_pop_if)
  );

  typedef struct {
    logic          pv;
    logic [31:0]   pd;
    logic          pr;
    logic          clr;
    logic [LW-1:0] aft;
    logic [LW-1:0] aet;
    logic          e_prdy;
    logic          e_pval;
    logic [31:0]   e_data;
    logic [LW-1:0] e_lvl;
    logic          e_af;
    logic          e_ae;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic pv, input logic [31:0] pd, input logic pr,
                              input logic clr, input logic [LW-1:0] aft, input logic [LW-1:0] aet,
                              input logic e_prdy, input logic e_pval, input logic [31:0] e_data,
                              input logic [LW-1:0] e_lvl, input logic e_af, input logic e_ae);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pr = pr; v.clr = clr; v.aft = aft; v.aet = aet;
    v.e_prdy = e_prdy; v.e_pval = e_pval; v.e_data = e_data;
    v.e_lvl = e_lvl; v.e_af = e_af; v.e_ae = e_ae;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pd, input logic pr, input logic clr);
    push_if.valid = pv;
    push_if.data  = pd;
    push_if.strb  = pd[3:0];
    pop_if.ready  = pr;
    clear_i       = clr;
  endtask

  task automatic drive_ft(input logic pv, input logic [31:0] pd, input logic pr);
    ft_push_if.valid = pv;
    ft_push_if.data  = pd;
    ft_push_if.strb  = pd[3:0];
    ft_pop_if.ready  = pr;
  endtask

  initial begin
    // Fill to full with pop stalled, hold a sixth word, then drain with wrap.
    add(1, 32'hA0, 0, 0, 3, 1,  1, 0, 32'h0,  0, 0, 1);
    add(1, 32'hA1, 0, 0, 3, 1,  1, 1, 32'hA0, 1, 0, 1);
    add(1, 32'hA2, 0, 0, 3, 1,  1, 1, 32'hA0, 2, 0, 0);
    add(1, 32'hA3, 0, 0, 3, 1,  1, 1, 32'hA0, 3, 1, 0);
    add(1, 32'hA4, 0, 0, 3, 1,  1, 1, 32'hA0, 4, 1, 0);
    add(1, 32'hA5, 0, 0, 3, 1,  0, 1, 32'hA0, 5, 1, 0);
    add(1, 32'hA5, 0, 0, 3, 1,  0, 1, 32'hA0, 5, 1, 0);
    add(0, 32'h0,  1, 0, 3, 1,  0, 1, 32'hA0, 5, 1, 0);
    add(0, 32'h0,  1, 0, 3, 1,  1, 1, 32'hA1, 4, 1, 0);
    add(0, 32'h0,  1, 0, 3, 1,  1, 1, 32'hA2, 3, 1, 0);
    add(0, 32'h0,  1, 0, 3, 1,  1, 1, 32'hA3, 2, 0, 0);
    add(0, 32'h0,  1, 0, 3, 1,  1, 1, 32'hA4, 1, 0, 1);
    add(0, 32'h0,  1, 0, 3, 1,  1, 0, 32'h0,  0, 0, 1);
    // Thresholds, including a same-cycle threshold change above the depth.
    add(1, 32'hB0, 0, 0, 3, 1,  1, 0, 32'h0,  0, 0, 1);
    add(1, 32'hB1, 0, 0, 3, 1,  1, 1, 32'hB0, 1, 0, 1);
    add(1, 32'hB2, 0, 0, 3, 1,  1, 1, 32'hB0, 2, 0, 0);
    add(0, 32'h0,  0, 0, 3, 1,  1, 1, 32'hB0, 3, 1, 0);
    add(0, 32'h0,  0, 0, 6, 1,  1, 1, 32'hB0, 3, 0, 0);
    add(0, 32'h0,  1, 0, 6, 1,  1, 1, 32'hB0, 3, 0, 0);
    // Ten simultaneous push/pop cycles at level 2.
    for (int i = 0; i < 10; i++)
      add(1, 32'hC0 + 32'(i), 1, 0, 6, 1, 1, 1,
          (i < 2) ? 32'hB1 + 32'(i) : 32'hC0 + 32'(i - 2), 2, 0, 0);
    // Refill to full; push+pop at full pops only.
    add(1, 32'hD0, 0, 0, 6, 1,  1, 1, 32'hC8, 2, 0, 0);
    add(1, 32'hD1, 0, 0, 6, 1,  1, 1, 32'hC8, 3, 0, 0);
    add(1, 32'hD2, 0, 0, 6, 1,  1, 1, 32'hC8, 4, 0, 0);
    add(1, 32'hD3, 1, 0, 6, 1,  0, 1, 32'hC8, 5, 0, 0);
    add(0, 32'h0,  0, 0, 4, 1,  1, 1, 32'hC9, 4, 1, 0);
    add(0, 32'h0,  1, 0, 4, 1,  1, 1, 32'hC9, 4, 1, 0);
    add(0, 32'h0,  0, 0, 4, 1,  1, 1, 32'hD0, 3, 0, 0);
    // Clear at level 3 during a push; the stale D words must never appear.
    add(1, 32'hE0, 0, 1, 4, 1,  1, 1, 32'hD0, 3, 0, 0);
    add(0, 32'h0,  0, 0, 4, 1,  1, 0, 32'h0,  0, 0, 1);
    add(1, 32'hF0, 0, 0, 4, 1,  1, 0, 32'h0,  0, 0, 1);
    add(0, 32'h0,  1, 0, 4, 1,  1, 1, 32'hF0, 1, 0, 1);
    add(0, 32'h0,  0, 0, 4, 1,  1, 0, 32'h0,  0, 0, 1);

    rst_i    = 1'b1;
    ft_clear = 1'b0;
    wm_clear = 1'b0;
    af_thr   = 3;
    ae_thr   = 1;
    drive(0, 32'h0, 0, 0);
    drive_ft(0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    @(negedge clk);
    check("rst push_ready", 32'(push_if.ready), 1);
    check("rst pop_valid",  32'(pop_if.valid), 0);
    check("rst level",      32'(flags.level), 0);
    check("rst empty",      32'(flags.empty), 1);
    check("rst full",       32'(flags.full), 0);
    check("rst almost_full", 32'(flags.almost_full), 0);
    check("rst almost_empty", 32'(flags.almost_empty), 1);
    check("rst ft pop_valid", 32'(ft_pop_if.valid), 0);
    check("rst ft empty",   32'(ft_flags.empty), 1);
    tick();

    foreach (vecs[k]) begin
      drive(vecs[k].pv, vecs[k].pd, vecs[k].pr, vecs[k].clr);
      af_thr = vecs[k].aft;
      ae_thr = vecs[k].aet;
      @(negedge clk);
      check($sformatf("v%0d push_ready", k), 32'(push_if.ready), 32'(vecs[k].e_prdy));
      check($sformatf("v%0d pop_valid", k),  32'(pop_if.valid), 32'(vecs[k].e_pval));
      if (vecs[k].e_pval) begin
        check($sformatf("v%0d pop_data", k), pop_if.data, vecs[k].e_data);
        check($sformatf("v%0d pop_strb", k), 32'(pop_if.strb), 32'(vecs[k].e_data[3:0]));
      end
      check($sformatf("v%0d level", k), 32'(flags.level), 32'(vecs[k].e_lvl));
      check($sformatf("v%0d empty", k), 32'(flags.empty), 32'(vecs[k].e_lvl == 0));
      check($sformatf("v%0d full", k),  32'(flags.full),  32'(vecs[k].e_lvl == LW'(DEPTH)));
      check($sformatf("v%0d almost_full", k),  32'(flags.almost_full),  32'(vecs[k].e_af));
      check($sformatf("v%0d almost_empty", k), 32'(flags.almost_empty), 32'(vecs[k].e_ae));
      tick();
    end

    // Watermark: restart tracking at level 0, fill to 3, then clear.
    drive(0, 32'h0, 0, 0);
    wm_clear = 1'b1;
    tick();
    wm_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h10 + 32'(i), 0, 0);
      tick();
    end
    drive(0, 32'h0, 0, 0);
    tick();
    @(negedge clk);
    check("wm level before clear", 32'(flags.level), 3);
`ifdef HWPE_STREAM_FIFO_THR_WATERMARK_EN
    check("wm max_level before clear", 32'(flags.max_level), 3);
`else
    check("wm max_level tied off", 32'(flags.max_level), 0);
`endif
    tick();
    drive(1, 32'h20, 0, 1);
    tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk);
    check("wm level after clear", 32'(flags.level), 0);
    check("wm empty after clear", 32'(flags.empty), 1);
    check("wm max_level after clear", 32'(flags.max_level), 0);
    tick();

    // Fall-through: pass-through when empty and ready, store when stalled.
    drive_ft(1, 32'h55, 1);
    @(negedge clk);
    check("ft bypass valid", 32'(ft_pop_if.valid), 1);
    check("ft bypass data",  ft_pop_if.data, 32'h55);
    check("ft bypass strb",  32'(ft_pop_if.strb), 32'h5);
    check("ft bypass level", 32'(ft_flags.level), 0);
    tick();
    drive_ft(0, 32'h0, 0);
    @(negedge clk);
    check("ft after bypass level", 32'(ft_flags.level), 0);
    check("ft after bypass valid", 32'(ft_pop_if.valid), 0);
    tick();
    drive_ft(1, 32'h66, 0);
    @(negedge clk);
    check("ft stall valid", 32'(ft_pop_if.valid), 1);
    check("ft stall data",  ft_pop_if.data, 32'h66);
    tick();
    drive_ft(0, 32'h0, 0);
    @(negedge clk);
    check("ft stored level", 32'(ft_flags.level), 1);
    check("ft stored data",  ft_pop_if.data, 32'h66);
    tick();
    drive_ft(1, 32'h77, 1);
    @(negedge clk);
    check("ft push+pop data",  ft_pop_if.data, 32'h66);
    tick();
    drive_ft(0, 32'h0, 1);
    @(negedge clk);
    check("ft push+pop level", 32'(ft_flags.level), 1);
    check("ft second data",    ft_pop_if.data, 32'h77);
    tick();
    drive_ft(0, 32'h0, 0);
    @(negedge clk);
    check("ft drained level", 32'(ft_flags.level), 0);
    check("ft drained valid", 32'(ft_pop_if.valid), 0);
    check("ft drained empty", 32'(ft_flags.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
